// File: rtl/spi_mem_if.sv
// Request/response bundle between the CPU fetch/load-store sequencer and spi_mem_master.
interface spi_mem_if #(
  parameter int unsigned NUM_CS     = 2,
  parameter int unsigned ADDR_BITS  = 24,
  parameter int unsigned DATA_BYTES = 4
) ();
  localparam int unsigned CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                    start;
  logic                    is_write;
  logic [CS_W-1:0]         cs_sel;
  logic [ADDR_BITS-1:0]    addr;
  logic [2:0]              num_bytes;
  logic [8*DATA_BYTES-1:0] wdata;
  logic [8*DATA_BYTES-1:0] rdata;
  logic                    done;
  logic                    err;
  logic                    busy;

  modport master (
    output start, is_write, cs_sel, addr, num_bytes, wdata,
    input  rdata, done, err, busy
  );

  modport slave (
    input  start, is_write, cs_sel, addr, num_bytes, wdata,
    output rdata, done, err, busy
  );
endinterface

// File: rtl/spi_mem_master.sv
// SPI mode-0 master for serial SRAM/flash: cmd, address, optional dummy byte, then data.
// Define SPI_FAST_READ_EN to issue 0x0B reads with 8 dummy SCLKs before the data phase.
module spi_mem_master #(
  parameter int unsigned NUM_CS     = 2,
  parameter int unsigned ADDR_BITS  = 24,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned CLK_DIV    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_mem_if.slave          bus,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);
  localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] RdCmd = 8'h0B;
`else
  localparam logic [7:0] RdCmd = 8'h03;
`endif

  typedef enum logic [2:0] {
    StIdle, StLatch, StCmd, StAddr,
`ifdef SPI_FAST_READ_EN
    StDummy,
`endif
    StData, StFinish, StDone
  } state_e;

  state_e                  state_q;
  logic                    wr_q;
  logic [CS_W-1:0]         cs_q;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [ADDR_BITS-1:0]    sr_q;
  logic [8*DATA_BYTES-1:0] wdata_q;
  logic [8*DATA_BYTES-1:0] rdata_q;
  logic [2:0]              nb_q;
  logic [2:0]              byte_q;
  logic [4:0]              bit_q;
  logic [DIV_W-1:0]        div_q;
  logic [6:0]              rx_q;
  logic                    done_q, err_q, busy_q, sclk_q, mosi_q;
  logic [NUM_CS-1:0]       cs_n_q;

  logic       cs_bad, half_end, last_bit;
  logic [7:0] cmd, nxt_byte;

  assign cs_bad   = ({1'b0, cs_q} >= (CS_W+1)'(NUM_CS));
  assign half_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign cmd      = wr_q ? 8'h02 : RdCmd;

  // Remaining 7 bits of a byte, MSB-aligned in the shift register (bit 7 is already on mosi).
  function automatic logic [ADDR_BITS-1:0] rest8(input logic [7:0] b);
    return ADDR_BITS'({b[6:0], 1'b0}) << (ADDR_BITS - 8);
  endfunction

  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      StCmd:   last_bit = (bit_q == 5'd7);
      StAddr:  last_bit = (bit_q == 5'(ADDR_BITS - 1));
`ifdef SPI_FAST_READ_EN
      StDummy: last_bit = (bit_q == 5'd7);
`endif
      StData:  last_bit = (bit_q == 5'd7);
      default: last_bit = 1'b0;
    endcase
  end

  always_comb begin
    nxt_byte = 8'h00;
    for (int k = 0; k < int'(DATA_BYTES); k++) begin
      if (byte_q + 3'd1 == 3'(k)) nxt_byte = wdata_q[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      cs_q    <= '0;
      addr_q  <= '0;
      sr_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      nb_q    <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      rx_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
    end else begin
      case (state_q)
        StIdle: if (bus.start) begin
          wr_q    <= bus.is_write;
          cs_q    <= bus.cs_sel;
          addr_q  <= bus.addr;
          wdata_q <= bus.wdata;
          nb_q    <= (bus.num_bytes > 3'(DATA_BYTES)) ? 3'(DATA_BYTES) : bus.num_bytes;
          rdata_q <= '0;
          busy_q  <= 1'b1;
          state_q <= StLatch;
        end
        StLatch: begin
          div_q  <= '0;
          bit_q  <= '0;
          byte_q <= '0;
          if (cs_bad || nb_q == 3'd0) begin
            err_q   <= cs_bad;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            cs_n_q  <= ~(NUM_CS'(1) << cs_q);
            mosi_q  <= cmd[7];
            sr_q    <= rest8(cmd);
            state_q <= StCmd;
          end
        end
        StCmd, StAddr,
`ifdef SPI_FAST_READ_EN
        StDummy,
`endif
        StData: begin
          if (!half_end) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              rx_q <= {rx_q[5:0], miso};
              if (state_q == StData && !wr_q && bit_q == 5'd7) begin
                for (int k = 0; k < int'(DATA_BYTES); k++) begin
                  if (byte_q == 3'(k)) rdata_q[8*k +: 8] <= {rx_q, miso};
                end
              end
            end else if (!last_bit) begin
              bit_q  <= bit_q + 5'd1;
              mosi_q <= sr_q[ADDR_BITS-1];
              sr_q   <= sr_q << 1;
            end else begin
              bit_q <= '0;
              case (state_q)
                StCmd: begin
                  mosi_q  <= addr_q[ADDR_BITS-1];
                  sr_q    <= addr_q << 1;
                  state_q <= StAddr;
                end
`ifdef SPI_FAST_READ_EN
                StAddr: begin
                  mosi_q  <= wr_q & wdata_q[7];
                  sr_q    <= wr_q ? rest8(wdata_q[7:0]) : '0;
                  state_q <= wr_q ? StData : StDummy;
                end
                StDummy: begin
                  mosi_q  <= 1'b0;
                  sr_q    <= '0;
                  state_q <= StData;
                end
`else
                StAddr: begin
                  mosi_q  <= wr_q & wdata_q[7];
                  sr_q    <= wr_q ? rest8(wdata_q[7:0]) : '0;
                  state_q <= StData;
                end
`endif
                default: begin
                  if (byte_q == nb_q - 3'd1) begin
                    mosi_q  <= 1'b0;
                    state_q <= StFinish;
                  end else begin
                    byte_q <= byte_q + 3'd1;
                    mosi_q <= wr_q & nxt_byte[7];
                    sr_q   <= wr_q ? rest8(nxt_byte) : '0;
                  end
                end
              endcase
            end
          end
        end
        StFinish: begin
          cs_n_q  <= '1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StDone;
        end
        StDone: if (!bus.start) begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;
endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
- Parametrised SPI-mode-0 master for serial SRAM/flash; successor to the fixed 2-chip-select memory controller used by the RV32E core.
- Generalised in chip-select count, address width, max transfer size and SCLK divider; adds an error flag and optional fast-read mode.
- Sits between the CPU fetch/load-store sequencer and the uo_out/ui_in pads; one transaction at a time, little-endian data.

Parameters:
- NUM_CS, 2, number of active-low chip selects (1..8).
- ADDR_BITS, 24, address bits shifted out; multiple of 8, range 8..32.
- DATA_BYTES, 4, maximum bytes per transaction (1..4).
- CLK_DIV, 1, clk cycles per SCLK half-period (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request; level, four-phase handshake with done
- is_write  in  1  1=write (cmd 0x02), 0=read (cmd 0x03)
- cs_sel  in  CS_W  chip index; CS_W = max(1, clog2(NUM_CS))
- addr  in  ADDR_BITS  byte address, MSB first on the wire
- num_bytes  in  3  bytes to transfer, 0..DATA_BYTES
- wdata  in  8*DATA_BYTES  write data; byte 0 (bits 7:0) sent first
- rdata  out  8*DATA_BYTES  read data; first received byte in bits 7:0
- done  out  1  transaction complete; held until start low
- err  out  1  valid while done; 1 = request rejected
- busy  out  1  high from accept until done
- sclk  out  1  SPI clock, idle low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- cs_n  out  NUM_CS  chip selects, idle all-ones

Behaviour:
- Reset (async, any state): IDLE; cs_n all ones, sclk=0, mosi=0, done=0, err=0, busy=0, rdata=0. Any in-flight transaction is abandoned.
- States: IDLE -> CMD -> ADDR -> [DUMMY] -> DATA -> FINISH -> DONE -> IDLE.
- IDLE: on the clk edge with start=1, latch all request inputs, clear rdata, and set busy=1. Later input changes are ignored until return to IDLE.
- Reject path: cs_sel>=NUM_CS or num_bytes==0 -> DONE on the next edge with err=(cs_sel>=NUM_CS). No SCLK activity and cs_n stays all ones.
- num_bytes>DATA_BYTES is clipped to DATA_BYTES; err=0.
- Accepted request: at the next edge, cs_n[cs_sel]=0 and mosi=cmd bit 7.
- Bit timing: sclk low CLK_DIV cycles, then high CLK_DIV cycles.
  - mosi changes only on the edge that drives sclk low.
  - miso is sampled on the edge that drives sclk high.
- Bit order:
  - cmd: 8 bits, MSB first.
  - addr: ADDR_BITS bits, MSB first.
  - data: byte k (k=0..N-1), each MSB first.
- Read: byte k is written into rdata[8k+7:8k] when its last bit is sampled. Unreceived bytes read as 0.
- Write: rdata stays 0. mosi=0 after the last bit.
- FINISH: after the last high half, sclk=0 and cs held low 1 cycle. Then cs_n all ones, done=1, busy=0.
- Latency: B = 8+ADDR_BITS+8N bits. done first high 2*CLK_DIV*B+2 cycles after the accepting edge.
- DONE: done=1 and rdata/err stable while start=1. When start=0: done=0, err=0, go to IDLE. A new request needs start low for at least one cycle.
- A start held high through DONE does not retrigger.
- At most one cs_n bit is low at any time.

Optional Feature:
- Macro: SPI_FAST_READ_EN.
- Defined:
  - Reads use cmd 0x0B and insert a DUMMY state of 8 SCLK cycles (mosi=0, miso ignored) between ADDR and DATA. B gains 8.
  - Writes are unchanged.
- Undefined: cmd 0x03, no DUMMY state, and the DUMMY encoding is absent.

Test Plan:
- Defaults; read cs_sel=1, addr=0x000104, N=4, miso model returns 0x13,0x05,0x00,0x00 -> cs_n=2'b01 during transfer; mosi stream 0x03,0x00,0x01,0x04; rdata=0x00000513; done 130 cycles after accept; err=0.
- Write cs_sel=0, addr=0x000010, N=2, wdata=0x0000BEEF -> mosi 0x02,0x00,0x00,0x10,0xEF,0xBE; 48 SCLK rising edges; cs_n=2'b10; rdata=0.
- CLK_DIV=3, read N=1, miso byte 0x80 -> sclk half-period 3 cycles; done at 2*3*40+2=242 cycles; rdata=0x00000080.
- Rejects: cs_sel=2 with NUM_CS=2 -> done+err=1 next cycle, no sclk edge. num_bytes=0 -> done, err=0, cs_n=2'b11 throughout.
- Handshake and reset:
  - Hold start high 10 cycles after done -> done stays 1, no second transfer.
  - Deassert rst_n mid-ADDR -> cs_n=2'b11, sclk=0, busy=0 immediately, without waiting for a clk edge.
- SPI_FAST_READ_EN defined, read N=4 -> cmd 0x0B, 8 dummy SCLKs, done 146 cycles after accept, rdata correct.
